// File: rtl/cactus_scroller.sv
// ---------------------------------------------------------------------------
// cactus_scroller
//
// Obstacle generator and scroller for the dino runner. It owns the two
// on-screen cacti and feeds their position, gap and heights straight into the
// collision detector. Once per frame tick, while the game is running, the
// cactus pair moves left by `speed` pixels. When the lead cactus would leave
// the screen it is recycled: the second cactus becomes the lead, and a fresh
// gap and height are drawn from a free-running 16-bit Galois LFSR.
//
// Ports:
//   i_clk               system clock
//   i_reset             synchronous, active-low reset
//   i_frame_tick        one-cycle pulse per video frame
//   i_run               game-running level from the game FSM
//   i_collision_detect  crash indication from the collision detector
//   i_speed     [3:0]   scroll step in pixels per frame
//   o_cactusX1  [8:0]   lead cactus X position
//   o_cactusRandDist [8:0] gap from the lead cactus to the second cactus
//   o_cactusHeight1 [8:0]  lead cactus height
//   o_cactusHeight2 [8:0]  second cactus height
//   o_moving            high exactly while the scroller is in RUN
//   o_pass_pulse        one-cycle pulse when a cactus is recycled (score tick)
// ---------------------------------------------------------------------------
module cactus_scroller #(
  parameter int SCREEN_W = 256,
  parameter int CACTUS_W = 16,
  parameter int DIST_MIN = 64,
  parameter int H_SHORT  = 20,
  parameter int H_TALL   = 35
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_run,
  input  logic       i_collision_detect,
  input  logic [3:0] i_speed,
  output logic [8:0] o_cactusX1,
  output logic [8:0] o_cactusRandDist,
  output logic [8:0] o_cactusHeight1,
  output logic [8:0] o_cactusHeight2,
  output logic       o_moving,
  output logic       o_pass_pulse
);

  // Spawn values shown while idle and reloaded whenever the game stops.
  localparam logic [8:0] SPAWN_X    = 9'(SCREEN_W);
  localparam logic [8:0] SPAWN_DIST = 9'(DIST_MIN);
  localparam logic [8:0] HEIGHT_LO  = 9'(H_SHORT);
  localparam logic [8:0] HEIGHT_HI  = 9'(H_TALL);

  // Galois LFSR for x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // With a legal parameter set the largest recycled position (lead at
  // speed-1, widest gap) plus the cactus width stays inside 9 bits, so
  // the recycle sum can simply be truncated. An illegal set saturates
  // instead of wrapping to a small on-screen value.
  localparam bit WRAP_FREE =
    (SCREEN_W + DIST_MIN + 127 + CACTUS_W) <= 511;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FROZEN
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [15:0] r_lfsr;
  logic [8:0]  r_x;
  logic [8:0]  r_dist;
  logic [8:0]  r_height1;
  logic [8:0]  r_height2;
  logic        r_moving;
  logic        r_pass;

  logic        w_loadSpawn;
  logic        w_step;
  logic        w_recycle;
  logic        w_lessThanSpeed;
  logic [15:0] w_lfsrShift;
  logic [15:0] w_lfsrNext;
  logic [9:0]  w_recycleSum;
  logic [8:0]  w_recycleX;
  logic [8:0]  w_gap;
  logic [8:0]  w_height;

  // LFSR feedback: when the bit shifted out is one, the tap mask is folded
  // into the shifted value. A non-zero seed keeps it off the all-zero state.
  assign w_lfsrShift = {1'b0, r_lfsr[15:1]};
  assign w_lfsrNext  = r_lfsr[0] ? (w_lfsrShift ^ LFSR_TAPS) : w_lfsrShift;

  // Fresh draws use the LFSR value present on the recycling edge.
  assign w_gap    = SPAWN_DIST + {2'b00, r_lfsr[6:0]};
  assign w_height = r_lfsr[7] ? HEIGHT_HI : HEIGHT_LO;

  // A recycle happens when one more step would carry the lead cactus past
  // the left edge. The second cactus sits r_dist pixels behind, so its new
  // position is the old lead position plus the gap, minus this frame's step.
  assign w_lessThanSpeed = r_x < {5'b00000, i_speed};
  assign w_recycleSum    = {1'b0, r_x} + {1'b0, r_dist} - {6'b000000, i_speed};
  assign w_recycleX      = (WRAP_FREE || !w_recycleSum[9]) ?
                           w_recycleSum[8:0] : 9'h1FF;

  // Next-state and datapath control. Collision has top priority in RUN so
  // the crash frame is frozen exactly as the detector saw it; dropping run
  // beats a frame tick so a stopped game never takes one last step.
  // Frame ticks only act when the scroller both is and stays in RUN.
  always_comb begin
    w_stateNext = r_state;
    w_loadSpawn = 1'b0;
    w_step      = 1'b0;
    w_recycle   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_loadSpawn = 1'b1;
        if (i_run) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (i_collision_detect) begin
          w_stateNext = S_FROZEN;
        end else if (!i_run) begin
          w_stateNext = S_IDLE;
          w_loadSpawn = 1'b1;
        end else if (i_frame_tick && (i_speed != 4'd0)) begin
          if (w_lessThanSpeed) begin
            w_recycle = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      S_FROZEN: begin
        if (!i_run) begin
          w_stateNext = S_IDLE;
          w_loadSpawn = 1'b1;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_loadSpawn = 1'b1;
      end
    endcase
  end

  // State register, LFSR and status flags. The LFSR free-runs in every
  // state so the draw depends on how long the player took to start and
  // survive. moving and pass_pulse are registered from next-cycle values
  // so they line up with the state and the recycled positions they describe.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_lfsr   <= LFSR_SEED;
      r_moving <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_lfsr   <= w_lfsrNext;
      r_moving <= (w_stateNext == S_RUN);
      r_pass   <= w_recycle;
    end
  end

  // Cactus position, gap and heights. On a recycle the second cactus's
  // height moves up to the lead slot and a new second cactus is drawn.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_x       <= SPAWN_X;
      r_dist    <= SPAWN_DIST;
      r_height1 <= HEIGHT_LO;
      r_height2 <= HEIGHT_LO;
    end else if (w_loadSpawn) begin
      r_x       <= SPAWN_X;
      r_dist    <= SPAWN_DIST;
      r_height1 <= HEIGHT_LO;
      r_height2 <= HEIGHT_LO;
    end else if (w_recycle) begin
      r_x       <= w_recycleX;
      r_dist    <= w_gap;
      r_height1 <= r_height2;
      r_height2 <= w_height;
    end else if (w_step) begin
      r_x       <= r_x - {5'b00000, i_speed};
    end
  end

  assign o_cactusX1       = r_x;
  assign o_cactusRandDist = r_dist;
  assign o_cactusHeight1  = r_height1;
  assign o_cactusHeight2  = r_height2;
  assign o_moving         = r_moving;
  assign o_pass_pulse     = r_pass;

endmodule

// File: doc/cactus_scroller.md
# cactus_scroller

Obstacle generator and scroller for the dino runner. It sits directly upstream of the collision detector. It owns the two on-screen cacti and drives the detector's cactusX1, cactusRandDist, cactusHeight1 and cactusHeight2 inputs. On each frame tick it moves the cactus pair left, recycles the lead cactus when it leaves the screen, and draws a new gap and height from a free-running LFSR.

## Interface
Parameters:
- SCREEN_W, 256: spawn X of the lead cactus (right edge of the play field).
- CACTUS_W, 16: cactus width in pixels. Must match the detector's cactusWidth.
- DIST_MIN, 64: minimum gap between the two cacti.
- H_SHORT, 20: short cactus height.
- H_TALL, 35: tall cactus height.
- Legality constraint: SCREEN_W + DIST_MIN + 127 + CACTUS_W ≤ 511, so no 9-bit sum in the detector can wrap.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- run  in  1  game-running level from the game FSM.
- collision_detect  in  1  from the collision detector.
- speed  in  4  scroll step in pixels per frame.
- cactusX1  out  9  lead cactus X.
- cactusRandDist  out  9  gap from lead to second cactus.
- cactusHeight1  out  9  lead cactus height.
- cactusHeight2  out  9  second cactus height.
- moving  out  1  high while in RUN.
- pass_pulse  out  1  one-cycle pulse when a cactus is recycled (score increment).

## Operation
- LFSR:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - Advances every clock while reset is high, in every state. It can never reach zero.
- Random draws use the LFSR value on the drawing clock edge:
  - gap = DIST_MIN + lfsr[6:0], giving the range [64,191].
  - height = lfsr[7] ? H_TALL : H_SHORT.
- States: IDLE, RUN, FROZEN.
- IDLE:
  - Outputs hold the spawn values: cactusX1=SCREEN_W, cactusRandDist=DIST_MIN, both heights=H_SHORT.
  - run=1 → RUN.
- RUN:
  - collision_detect=1 → FROZEN. Positions do not update that cycle, even when frame_tick is also high (collision wins).
  - run=0 → IDLE, reloading the spawn values. This takes priority over frame_tick but not over collision.
  - frame_tick=1 and cactusX1 ≥ speed (normal step): cactusX1 ← cactusX1 − speed.
  - frame_tick=1 and cactusX1 < speed (recycle):
    - cactusX1 ← cactusX1 + cactusRandDist − speed, computed at 10 bits then truncated (always < 512 by the legality constraint).
    - cactusHeight1 ← cactusHeight2.
    - cactusRandDist ← new gap; cactusHeight2 ← new height.
    - pass_pulse=1 on the following cycle.
  - speed=0: nothing moves and nothing recycles.
- FROZEN:
  - All positions and heights hold, so the game-over screen shows the crash.
  - run=0 → IDLE. Ignore collision_detect and frame_tick.
- Reset (reset=0 on a clock edge), including mid-run:
  - State=IDLE, spawn values loaded, LFSR=16'hACE1, moving=0, pass_pulse=0.

## Timing
- All outputs are registered.
- Position and height updates are visible on the cycle after the clk edge that sampled frame_tick.
- pass_pulse:
  - Asserted in the same cycle the recycled values first appear.
  - Width is exactly one cycle, with at most one pulse per frame_tick.
- moving is high exactly in the cycles where state = RUN. It rises one cycle after run is first sampled high in IDLE.
- collision_detect is combinational from these outputs:
  - It is sampled every clock in RUN.
  - The FROZEN entry edge must not move the cacti.
- frame_tick is ignored in IDLE and FROZEN, including when it arrives coincident with a state change.

## Test plan
- Reset and IDLE hold:
  - Stimulus: hold reset=0 for 2 cycles, release, run=0, apply frame_ticks.
  - Required: cactusX1=256, cactusRandDist=64, heights=20/20, moving=0, pass_pulse=0, and nothing moves.
- Scroll:
  - Stimulus: run=1, speed=4, 3 frame_ticks.
  - Required: cactusX1 = 252, then 248, then 244. Each step appears one cycle after its tick. Gap and heights unchanged.
- Recycle:
  - Stimulus: force cactusX1=3, cactusRandDist=100, height2=35, speed=5, one frame_tick.
  - Required:
    - cactusX1=98, cactusHeight1=35.
    - cactusRandDist in [64,191], equal to 64+lfsr[6:0] at that edge.
    - cactusHeight2 ∈ {20,35}.
    - pass_pulse high for exactly 1 cycle.
- Collision with simultaneous tick:
  - Stimulus: cactusX1=120 in RUN, collision_detect=1 and frame_tick=1 on the same edge.
  - Required:
    - cactusX1 stays 120 and moving=0.
    - Later ticks do nothing.
    - run=0 returns to IDLE with cactusX1=256.
- Speed zero and run drop:
  - Stimulus: speed=0, 10 ticks, then run=0 mid-run.
  - Required: cactusX1 is unchanged with no pass_pulse, then IDLE with spawn values on the next cycle.
- Reset mid-run:
  - Stimulus: reset=0 for 1 cycle while in RUN with cactusX1=57.
  - Required: next cycle shows IDLE, cactusX1=256, LFSR reseeded, and the first draw after reset is reproducible.
